win_banner_renderer: RTL

//   Upstream address generator and downstream compositor for the 256x192 win-banner frame ROM.

---
 rtl/win_banner_pkg.sv | 21 ++
 rtl/banner_addr_map.sv | 39 +++
 rtl/win_banner_renderer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/win_banner_pkg.sv
// Shared types and constants for the win-banner overlay path.
package win_banner_pkg;

    // Screen geometry of the 640x480 VGA raster.
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned COORD_W  = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

    // Pixel colour width and the transparent chroma-key colour.
    localparam int unsigned RGB_W     = 24;
    localparam logic [RGB_W-1:0] KEY_COLOR = 24'hFF0000;

    // Banner display sequencing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLINK = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } banner_state_t;

endpackage

// File: rtl/banner_addr_map.sv
// Combinational screen-to-ROM address mapping for a scaled, offset banner image.
module banner_addr_map
    import win_banner_pkg::*;
#(
    parameter int unsigned IMG_W       = 256,
    parameter int unsigned IMG_H       = 192,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned X0          = 64,
    parameter int unsigned Y0          = 48,
    parameter int unsigned ADDR_W      = 19
) (
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               in_box_c,
    output logic [ADDR_W-1:0]  addr_c
);

    localparam int unsigned OFF_W  = COORD_W + 1;
    localparam int unsigned SPAN_X = IMG_W << SCALE_SHIFT;
    localparam int unsigned SPAN_Y = IMG_H << SCALE_SHIFT;

    logic [OFF_W-1:0] dx;
    logic [OFF_W-1:0] dy;
    logic [OFF_W-1:0] rx;
    logic [OFF_W-1:0] ry;

    // Offsets one bit wider than the coordinate: a pixel left of/above the box wraps
    // to >= 2**COORD_W, which is always beyond the span, so the single unsigned
    // compare rejects it.
    always_comb begin
        dx       = {1'b0, draw_x} - OFF_W'(X0);
        dy       = {1'b0, draw_y} - OFF_W'(Y0);
        rx       = dx >> SCALE_SHIFT;
        ry       = dy >> SCALE_SHIFT;
        in_box_c = (dx < OFF_W'(SPAN_X)) && (dy < OFF_W'(SPAN_Y));
        addr_c   = ADDR_W'(ry) * ADDR_W'(IMG_W) + ADDR_W'(rx);
    end

endmodule

// File: rtl/win_banner_renderer.sv
// Win-banner ROM address generator, chroma-key compositor and blink/hold sequencer.
module win_banner_renderer
    import win_banner_pkg::*;
#(
    parameter int unsigned IMG_W         = 256,
    parameter int unsigned IMG_H         = 192,
    parameter int unsigned SCALE_SHIFT   = 1,
    parameter int unsigned X0            = 64,
    parameter int unsigned Y0            = 48,
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned BLINK_FRAMES  = 15,
    parameter int unsigned BLINK_TOGGLES = 6,
    parameter int unsigned HOLD_FRAMES   = 180
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic               show_req,
    input  logic               clear,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [RGB_W-1:0]   bg_rgb,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [RGB_W-1:0]   rom_data,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               overlay_active,
    output logic               done
);

    localparam int unsigned CNT_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned TOG_W   = $clog2(BLINK_TOGGLES + 1);

    banner_state_t      state;
    banner_state_t      state_next;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_cnt_next;
    logic [TOG_W-1:0]   tog_cnt;
    logic [TOG_W-1:0]   tog_cnt_next;
    logic               visible;
    logic               visible_next;

    logic               blink_wrap;
    logic               last_toggle;
    logic               hold_wrap;

    logic               in_box_c;
    logic [ADDR_W-1:0]  addr_c;

    logic               in_box_d1;
    logic               in_box_d2;
    logic               vis_d1;
    logic               vis_d2;
    logic [RGB_W-1:0]   bg_d1;
    logic [RGB_W-1:0]   bg_d2;

    banner_addr_map #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .SCALE_SHIFT (SCALE_SHIFT),
        .X0          (X0),
        .Y0          (Y0),
        .ADDR_W      (ADDR_W)
    ) u_addr_map (
        .draw_x   (DrawX),
        .draw_y   (DrawY),
        .in_box_c (in_box_c),
        .addr_c   (addr_c)
    );

    assign blink_wrap  = (frame_cnt == CNT_W'(BLINK_FRAMES - 1));
    assign last_toggle = (tog_cnt == TOG_W'(BLINK_TOGGLES - 1));
    assign hold_wrap   = (frame_cnt == CNT_W'(HOLD_FRAMES - 1));

    // FSM state, counters and status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            frame_cnt      <= '0;
            tog_cnt        <= '0;
            visible        <= 1'b0;
            overlay_active <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_next;
            frame_cnt      <= frame_cnt_next;
            tog_cnt        <= tog_cnt_next;
            visible        <= visible_next;
            overlay_active <= (state_next != IDLE);
            done           <= (state_next == DONE);
        end
    end

    // Next state: clear always wins, otherwise frame-synchronous progression.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (show_req) state_next = BLINK;
                BLINK:   if (frame_start && blink_wrap && last_toggle) state_next = HOLD;
                HOLD:    if (frame_start && hold_wrap) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Counter and visibility updates; visibility only moves on frame_start except at entry.
    always_comb begin
        frame_cnt_next = frame_cnt;
        tog_cnt_next   = tog_cnt;
        visible_next   = visible;
        if (clear) begin
            frame_cnt_next = '0;
            tog_cnt_next   = '0;
            visible_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    visible_next = 1'b0;
                    if (show_req) begin
                        frame_cnt_next = '0;
                        tog_cnt_next   = '0;
                        visible_next   = 1'b1;
                    end
                end
                BLINK: begin
                    if (frame_start) begin
                        if (blink_wrap) begin
                            frame_cnt_next = '0;
                            if (last_toggle) begin
                                tog_cnt_next = '0;
                                visible_next = 1'b1;
                            end else begin
                                tog_cnt_next = tog_cnt + TOG_W'(1);
                                visible_next = ~visible;
                            end
                        end else begin
                            frame_cnt_next = frame_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    visible_next = 1'b1;
                    if (frame_start) begin
                        frame_cnt_next = hold_wrap ? '0 : frame_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    visible_next = 1'b1;
                end
                default: begin
                    visible_next = 1'b0;
                end
            endcase
        end
    end

    // Three-stage pixel pipe: address issue, ROM wait, chroma-key composite.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
            vis_d1    <= 1'b0;
            vis_d2    <= 1'b0;
            bg_d1     <= '0;
            bg_d2     <= '0;
            rgb_out   <= '0;
        end else begin
            rom_addr  <= in_box_c ? addr_c : '0;
            in_box_d1 <= in_box_c;
            vis_d1    <= visible;
            bg_d1     <= bg_rgb;
            in_box_d2 <= in_box_d1;
            vis_d2    <= vis_d1;
            bg_d2     <= bg_d1;
            rgb_out   <= (in_box_d2 && vis_d2 && (rom_data != KEY_COLOR)) ? rom_data : bg_d2;
        end
    end

endmodule
